victim_writeback_buffer: RTL and testbench

- Sits directly downstream of the 4-way cache's MSHR victim port.
- Collects the dirty victim words the cache emits one per cycle, in any word order, into a line entry. Once all words of a line are present, writes the line back to memory, one word per req/ack transaction.
- Gives the cache a probe port so that a refill of a line still waiting for write-back is detected, which prevents a read-after-writeback hazard.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/victim_writeback_buffer_if.sv | 41 ++++
 rtl/wb_line_entry.sv | 50 +++++
 rtl/victim_writeback_buffer.sv | 157 +++++++++++++++
 tb/tb_victim_writeback_buffer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache constants, drain state encoding and the victim line entry record
// used by the victim write-back buffer and its line entries.
package cache_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int ADR_WIDTH         = 32;
  localparam int WORD_NUM          = 4;
  localparam int WORD_OFFSET_WIDTH = 2;
  localparam int BYTE_OFFSET_WIDTH = 2;

  // Address slicing: [tag | word offset | byte offset]; the cache index sits in
  // the low tag bits, so a full-tag compare identifies a line uniquely.
  localparam int BYTE_LSB  = 0;
  localparam int WORD_LSB  = BYTE_LSB + BYTE_OFFSET_WIDTH;
  localparam int TAG_LSB   = WORD_LSB + WORD_OFFSET_WIDTH;
  localparam int INDEX_LSB = TAG_LSB;
  localparam int TAG_WIDTH = ADR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    POP  = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]                 tag;
    logic [WORD_NUM-1:0][WORD_WIDTH-1:0]  data;
    logic [WORD_NUM-1:0]                  mask;
    logic                                 valid;
  } entry_t;

endpackage

// File: rtl/victim_writeback_buffer_if.sv
// Victim, probe and write-back signal bundle of the victim write-back buffer.
// VICTIM_WB_FORWARD_EN adds the probe forwarding outputs.
interface victim_writeback_buffer_if;
  import cache_pkg::*;

  logic                         vic_valid_i;
  logic [ADR_WIDTH-1:0]         vic_adr_i;
  logic [WORD_OFFSET_WIDTH-1:0] vic_word_i;
  logic [WORD_WIDTH-1:0]        vic_dat_i;
  logic                         full_o;
  logic [ADR_WIDTH-1:0]         probe_adr_i;
  logic                         probe_hit_o;
  logic                         wb_req_o;
  logic [ADR_WIDTH-1:0]         wb_adr_o;
  logic [WORD_WIDTH-1:0]        wb_dat_o;
  logic                         wb_ack_i;

`ifdef VICTIM_WB_FORWARD_EN
  logic [WORD_WIDTH-1:0]        probe_dat_o;
  logic                         probe_word_vld_o;

  modport slave (
    input  vic_valid_i, vic_adr_i, vic_word_i, vic_dat_i, probe_adr_i, wb_ack_i,
    output full_o, probe_hit_o, wb_req_o, wb_adr_o, wb_dat_o, probe_dat_o, probe_word_vld_o
  );
  modport master (
    output vic_valid_i, vic_adr_i, vic_word_i, vic_dat_i, probe_adr_i, wb_ack_i,
    input  full_o, probe_hit_o, wb_req_o, wb_adr_o, wb_dat_o, probe_dat_o, probe_word_vld_o
  );
`else
  modport slave (
    input  vic_valid_i, vic_adr_i, vic_word_i, vic_dat_i, probe_adr_i, wb_ack_i,
    output full_o, probe_hit_o, wb_req_o, wb_adr_o, wb_dat_o
  );
  modport master (
    output vic_valid_i, vic_adr_i, vic_word_i, vic_dat_i, probe_adr_i, wb_ack_i,
    input  full_o, probe_hit_o, wb_req_o, wb_adr_o, wb_dat_o
  );
`endif

endinterface

// File: rtl/wb_line_entry.sv
// One victim line slot: tag, word storage, word-present mask, completion and
// probe tag compare.
module wb_line_entry
  import cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [TAG_WIDTH-1:0]         wr_tag_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] wr_word_i,
  input  logic [WORD_WIDTH-1:0]        wr_dat_i,
  input  logic                         clr_i,
  input  logic [TAG_WIDTH-1:0]         probe_tag_i,
  output entry_t                       entry_o,
  output logic                         complete_o,
  output logic                         done_o,
  output logic                         hit_o
);

  entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clr_i) begin
      entry_d = '0;
    end else if (wr_en_i) begin
      // Tag is captured only by the first word; later words of the line reuse it.
      if (!entry_q.valid) begin
        entry_d.tag = wr_tag_i;
      end
      entry_d.valid           = 1'b1;
      entry_d.mask[wr_word_i] = 1'b1;
      entry_d.data[wr_word_i] = wr_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o    = entry_q;
  assign complete_o = entry_q.valid & (&entry_q.mask);
  assign done_o     = wr_en_i & ~clr_i & ~complete_o & (&entry_d.mask);
  assign hit_o      = entry_q.valid & (entry_q.tag == probe_tag_i);

endmodule

// File: rtl/victim_writeback_buffer.sv
// Victim write-back buffer: gathers dirty victim words into line entries and
// drains complete lines one word per req/ack. VICTIM_WB_FORWARD_EN adds probe forwarding.
module victim_writeback_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                      clk,
  input logic                      rst,
  victim_writeback_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_WORD = WORD_OFFSET_WIDTH'(WORD_NUM - 1);

  drain_state_e                 state_q, state_d;
  logic [PTR_W-1:0]             fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]             drain_ptr_q, drain_ptr_d;
  logic [PTR_W:0]               count_q, count_d;
  logic [WORD_OFFSET_WIDTH-1:0] word_cnt_q, word_cnt_d;

  entry_t               entries [DEPTH];
  logic [DEPTH-1:0]     complete_vec, done_vec, hit_vec;
  logic                 full, wr_en, fill_done, pop, wb_req, probe_hit;
  logic [TAG_WIDTH-1:0] vic_tag, probe_tag;
  logic                 unused_offset_bits;

  assign vic_tag   = bus.vic_adr_i[ADR_WIDTH-1:TAG_LSB];
  assign probe_tag = bus.probe_adr_i[ADR_WIDTH-1:TAG_LSB];
  assign unused_offset_bits = ^{bus.vic_adr_i[TAG_LSB-1:0], bus.probe_adr_i[WORD_LSB-1:0]};

  assign full      = (count_q == FULL_CNT);
  assign wr_en     = bus.vic_valid_i & ~full;
  assign fill_done = |done_vec;
  assign probe_hit = |hit_vec;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic unused_entry_flags;

      wb_line_entry u_entry (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en && (fill_ptr_q == PTR_W'(gi))),
        .wr_tag_i    (vic_tag),
        .wr_word_i   (bus.vic_word_i),
        .wr_dat_i    (bus.vic_dat_i),
        .clr_i       (pop && (drain_ptr_q == PTR_W'(gi))),
        .probe_tag_i (probe_tag),
        .entry_o     (entries[gi]),
        .complete_o  (complete_vec[gi]),
        .done_o      (done_vec[gi]),
        .hit_o       (hit_vec[gi])
      );

      assign unused_entry_flags = ^{entries[gi].mask, entries[gi].valid};
    end
  endgenerate

  // A line completing into the drain slot is seen in the same cycle, so the
  // first request follows completion by one cycle.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    wb_req     = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (complete_vec[drain_ptr_q] || done_vec[drain_ptr_q]) begin
          word_cnt_d = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        wb_req = 1'b1;
        if (bus.wb_ack_i) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            state_d = POP;
          end
        end
      end
      POP: begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_ptr_d  = fill_done ? fill_ptr_q + 1'b1 : fill_ptr_q;
    drain_ptr_d = pop ? drain_ptr_q + 1'b1 : drain_ptr_q;
    count_d     = count_q;
    unique case ({fill_done, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_ptr_q  <= '0;
      drain_ptr_q <= '0;
      count_q     <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign bus.full_o      = full;
  assign bus.probe_hit_o = probe_hit;
  assign bus.wb_req_o    = wb_req;
  assign bus.wb_adr_o    = wb_req ? {entries[drain_ptr_q].tag, word_cnt_q, {BYTE_OFFSET_WIDTH{1'b0}}} : '0;
  assign bus.wb_dat_o    = wb_req ? entries[drain_ptr_q].data[word_cnt_q] : '0;

`ifdef VICTIM_WB_FORWARD_EN
  logic [PTR_W-1:0]             fwd_idx, scan_idx;
  logic [WORD_OFFSET_WIDTH-1:0] probe_word;

  assign probe_word = bus.probe_adr_i[TAG_LSB-1:WORD_LSB];

  // Scan oldest to newest so the newest match overwrites; a partial fill slot is newest of all.
  always_comb begin
    fwd_idx  = fill_ptr_q;
    scan_idx = fill_ptr_q;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      scan_idx = fill_ptr_q - PTR_W'(k + 1);
      if (hit_vec[scan_idx]) begin
        fwd_idx = scan_idx;
      end
    end
    if (hit_vec[fill_ptr_q] && !complete_vec[fill_ptr_q]) begin
      fwd_idx = fill_ptr_q;
    end
  end

  assign bus.probe_dat_o      = probe_hit ? entries[fwd_idx].data[probe_word] : '0;
  assign bus.probe_word_vld_o = probe_hit & entries[fwd_idx].mask[probe_word];
`else
  logic unused_probe_word;
  assign unused_probe_word = ^bus.probe_adr_i[TAG_LSB-1:WORD_LSB];
`endif

`ifndef SYNTHESIS
  fill_when_full_a: assert property (@(posedge clk) disable iff (rst) !(bus.vic_valid_i && full));
`endif

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Directed bench for victim_writeback_buffer (DEPTH=2): fill order, stalls,
// full handling, probing, reset mid-drain and fill/pop overlap.
module tb_victim_writeback_buffer;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  victim_writeback_buffer_if vif ();

  victim_writeback_buffer #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offset bits of the address are set to junk; the buffer must ignore them.
  task automatic send(input logic [31:0] adr, input int w, input logic [31:0] dat);
    vif.vic_valid_i = 1'b1;
    vif.vic_adr_i   = adr | 32'hF;
    vif.vic_word_i  = 2'(w);
    vif.vic_dat_i   = dat;
    $display("victim word adr=0x%08h word=%0d dat=0x%08h", adr, w, dat);
    tick();
    vif.vic_valid_i = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!vif.wb_req_o && n < 20) begin
      tick();
      n++;
    end
    check(tag, vif.wb_req_o, 1'b1);
  endtask

  task automatic ack_word(input logic [31:0] adr, input logic [31:0] dat);
    check("wb_adr", vif.wb_adr_o, adr);
    check("wb_dat", vif.wb_dat_o, dat);
    $display("wb write adr=0x%08h dat=0x%08h", vif.wb_adr_o, vif.wb_dat_o);
    vif.wb_ack_i = 1'b1;
    tick();
    vif.wb_ack_i = 1'b0;
  endtask

  // Returns in the POP cycle of the drained line.
  task automatic drain(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3,
                       input int stall_w, input int stall_n);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int w = 0; w < 4; w++) begin
      wait_req("drain_req");
      if (w == stall_w) begin
        for (int s = 0; s < stall_n; s++) begin
          check("stall_req", vif.wb_req_o, 1'b1);
          check("stall_adr", vif.wb_adr_o, base + 32'(4 * w));
          check("stall_dat", vif.wb_dat_o, d[w]);
          tick();
        end
      end
      ack_word(base + 32'(4 * w), d[w]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vif.vic_valid_i = 1'b0;
    vif.vic_adr_i   = '0;
    vif.vic_word_i  = '0;
    vif.vic_dat_i   = '0;
    vif.probe_adr_i = '0;
    vif.wb_ack_i    = 1'b0;
    tick();
    tick();

    check("reset_full", vif.full_o, 1'b0);
    check("reset_req", vif.wb_req_o, 1'b0);
    check("reset_adr", vif.wb_adr_o, 32'h0);
    check("reset_dat", vif.wb_dat_o, 32'h0);
    check("reset_hit", vif.probe_hit_o, 1'b0);
    rst = 1'b0;
    tick();

    // Stray ack while idle is ignored.
    vif.wb_ack_i = 1'b1;
    tick();
    vif.wb_ack_i = 1'b0;
    check("idle_ack_req", vif.wb_req_o, 1'b0);

    // Line 0x1230, words 2,3,0,1; probe while partial.
    vif.probe_adr_i = 32'h0000_1238;
    #1;
    check("probe_empty", vif.probe_hit_o, 1'b0);
    send(32'h0000_1230, 2, 32'hA2);
    check("probe_partial_hit", vif.probe_hit_o, 1'b1);
`ifdef VICTIM_WB_FORWARD_EN
    check("fwd_dat_w2", vif.probe_dat_o, 32'hA2);
    check("fwd_vld_w2", vif.probe_word_vld_o, 1'b1);
`endif
    vif.probe_adr_i = 32'h0000_1234;
    #1;
    check("probe_partial_hit_w1", vif.probe_hit_o, 1'b1);
`ifdef VICTIM_WB_FORWARD_EN
    check("fwd_dat_w1", vif.probe_dat_o, 32'h0);
    check("fwd_vld_w1", vif.probe_word_vld_o, 1'b0);
`endif
    send(32'h0000_1230, 3, 32'hA3);
    send(32'h0000_1230, 0, 32'hA0);
    check("req_before_4th", vif.wb_req_o, 1'b0);
    send(32'h0000_1230, 1, 32'hA1);
    check("req_after_4th", vif.wb_req_o, 1'b1);
    drain(32'h0000_1230, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, 5);
    check("pop_req", vif.wb_req_o, 1'b0);
    check("pop_hit", vif.probe_hit_o, 1'b1);
    tick();
    check("after_pop_hit", vif.probe_hit_o, 1'b0);

    // Two complete lines with no acks fill the buffer.
    for (int w = 0; w < 4; w++) send(32'h0000_2000, w, 32'hB0 + 32'(w));
    for (int w = 3; w > 0; w--) send(32'h0000_3000, w, 32'hC0 + 32'(w));
    check("full_before", vif.full_o, 1'b0);
    send(32'h0000_3000, 0, 32'hC0);
    check("full_two_lines", vif.full_o, 1'b1);
    vif.probe_adr_i = 32'h0000_3004;
    #1;
    check("probe_full_hit", vif.probe_hit_o, 1'b1);
    drain(32'h0000_2000, 32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, 0);
    check("pop_still_full", vif.full_o, 1'b1);
    tick();
    check("full_after_pop", vif.full_o, 1'b0);
    check("gap_req", vif.wb_req_o, 1'b0);
    tick();
    check("next_req_2cyc", vif.wb_req_o, 1'b1);
    drain(32'h0000_3000, 32'hC0, 32'hC1, 32'hC2, 32'hC3, -1, 0);
    tick();

    // Reset while requesting word 2.
    for (int w = 0; w < 4; w++) send(32'h0000_5000, w, 32'hD0 + 32'(w));
    for (int w = 0; w < 4; w++) send(32'h0000_5100, w, 32'hE0 + 32'(w));
    check("full_pre_rst", vif.full_o, 1'b1);
    wait_req("rst_req");
    ack_word(32'h0000_5000, 32'hD0);
    ack_word(32'h0000_5004, 32'hD1);
    check("rst_word2_adr", vif.wb_adr_o, 32'h0000_5008);
    vif.probe_adr_i = 32'h0000_5100;
    #1;
    check("hit_pre_rst", vif.probe_hit_o, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_req", vif.wb_req_o, 1'b0);
    check("rst_full", vif.full_o, 1'b0);
    check("rst_hit", vif.probe_hit_o, 1'b0);
    rst = 1'b0;
    for (int w = 0; w < 4; w++) send(32'h0000_6000, w, 32'h60 + 32'(w));
    check("fresh_req", vif.wb_req_o, 1'b1);
    drain(32'h0000_6000, 32'h60, 32'h61, 32'h62, 32'h63, -1, 0);
    tick();

    // Next line completes in the POP cycle of the previous one.
    for (int w = 0; w < 4; w++) send(32'h0000_7000, w, 32'h70 + 32'(w));
    for (int w = 0; w < 3; w++) send(32'h0000_8000, w, 32'h80 + 32'(w));
    drain(32'h0000_7000, 32'h70, 32'h71, 32'h72, 32'h73, -1, 0);
    check("pop_full_sim", vif.full_o, 1'b0);
    send(32'h0000_8000, 3, 32'h83);
    check("simul_full", vif.full_o, 1'b0);
    check("simul_gap_req", vif.wb_req_o, 1'b0);
    tick();
    check("simul_req", vif.wb_req_o, 1'b1);
    drain(32'h0000_8000, 32'h80, 32'h81, 32'h82, 32'h83, -1, 0);
    tick();
    check("end_full", vif.full_o, 1'b0);
    check("end_req", vif.wb_req_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
